gf_pow_engine: RTL
==================

# gf_pow_engine

Iterative power-map engine computing y = x^E over GF(2^N) for LANES independent field elements in parallel, with a runtime-programmable exponent. It generalises the fixed six-bit power-map S-box datapath into a parametrised, handshaked, multi-cycle unit. It sits between a basis-conversion front end and the S-box evaluation/characterisation harness. It also covers power-map inverses (exponent 2^N−2) and arbitrary monomial S-boxes without regenerating RTL.

## Interface
Parameters:
- N, 6, field degree; legal range 2..16.
- POLY, 7'b1000011, irreducible modulus of width N+1; MSB must be 1 (default x^6+x+1).
- LANES, 1, number of parallel elements sharing one exponent.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  engine can accept a request.
- in_x  in  LANES*N  operands; lane k occupies bits [k*N +: N].
- in_exp  in  N  exponent E, unsigned, 0..2^N−1.
- out_valid  out  1  result held on out_y.
- out_ready  in  1  consumer accepts the result.
- out_y  out  LANES*N  results x_k^E, same lane packing as in_x.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1.
  - IDLE→RUN on in_valid & in_ready. Capture in_x and in_exp into internal registers, set acc_k=1 for each lane, set bit counter cnt=N−1.
  - RUN: each edge applies acc_k ← acc_k² · (exp[cnt] ? x_k : 1), processing the exponent MSB-first, then decrements cnt.
  - RUN→DONE on the edge that processes cnt=0.
  - DONE: out_valid=1 and out_y=acc. Both are held stable until out_ready.
  - DONE→IDLE on out_ready.
- Arithmetic:
  - Polynomial basis, bit i is the coefficient of α^i.
  - Products are reduced modulo POLY and are always fully reduced N-bit values.
  - Squaring uses the same multiplier, or a dedicated linear squarer; the result must be bit-identical either way.
- Boundary values:
  - E=0 gives 1 for every lane, including x=0 (0^0 is defined as 1).
  - x=0 with E≠0 gives 0.
  - x=1 gives 1 for any E.
- Capture and change rules:
  - in_x and in_exp are sampled only at acceptance.
  - Changes to in_x or in_exp during RUN or DONE have no effect.
  - in_valid while busy is ignored (no acceptance, no queueing).
- Reset:
  - Reset asserted at any time, including mid-RUN, returns the engine to IDLE and discards the operation. No partial result is ever presented.
  - Reset values: in_ready=1, out_valid=0, busy=0, out_y=0; internal acc, x, exp and cnt all 0.

## Timing
- Acceptance edge is t.
- RUN edges are t+1 … t+N.
- out_valid is high in the cycle after edge t+N.
- Latency is N cycles from acceptance to out_valid.
- With out_ready held high, throughput is one request per N+2 cycles: IDLE, N RUN, DONE.
- in_ready is combinational from state only and never depends on in_valid.
- out_valid/out_y are registered; no combinational path runs from any input to any output.
- Multiplier critical path is one GF(2^N) multiply plus one square per cycle. No multicycle constraints are allowed.

## Structure
- Package gf_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the default POLY constants for N=4, 6, 8 (x^4+x+1, x^6+x+1, x^8+x^4+x^3+x+1);
  - the function computing reduction of a 2N−1 bit product.
- One sub-module, gf_mul: combinational N-bit multiplier modulo POLY, parameterised by N and POLY.
  - Instantiated per lane; squaring reuses it or the package function.
- Lane datapaths are generated with a generate loop; the FSM and counter are shared across lanes.

## Test plan
- N=6, LANES=1, x=0x02, E=1 → y=0x02; E=2 → 0x04; E=6 → 0x03; E=7 → 0x06. out_valid rises exactly 6 cycles after acceptance.
- N=6, x=0x02, E=62 → y=0x21 (α⁻¹). E=63 → y=0x01. x=0x00, E=0 → 0x01. x=0x00, E=52 → 0x00.
- N=6, LANES=4, in_x={0x01,0x00,0x02,0x02}, E=7 → out_y={0x01,0x00,0x06,0x06}. Exhaustive sweep of all 64×64 (x,E) pairs checked against a software square-and-multiply model.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE; out_y stays stable and in_ready stays 0.
  - in_valid pulses while busy are not accepted.
  - Change in_x during RUN; the result still reflects the captured operand.
- Assert rst_n=0 asynchronously at RUN edge t+3 → all outputs return to reset values immediately. After release, a new request (x=0x02, E=2) returns 0x04 with normal latency.
- N=8, POLY=9'h11B, x=0x53, E=254 → y=0xCA (AES inverse). N=4, POLY=5'b10011, x=0x2, E=14 → y=0x9.

Source files
------------

// File: rtl/gf_pkg.sv
// Shared types, default field moduli and the polynomial reduction helper
// used by the GF(2^N) power-map engine.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_t;

  localparam int MAX_N = 16;

  localparam logic [4:0] POLY_N4 = 5'b10011;       // x^4+x+1
  localparam logic [6:0] POLY_N6 = 7'b1000011;     // x^6+x+1
  localparam logic [8:0] POLY_N8 = 9'b100011011;   // x^8+x^4+x^3+x+1

  // Reduces a (2n-1)-bit carry-less product modulo poly; bits above 2n-2 are ignored.
  function automatic logic [MAX_N-1:0] gf_reduce(
    input logic [2*MAX_N-2:0] prod,
    input logic [MAX_N:0]     poly,
    input int                 n
  );
    logic [2*MAX_N-2:0] r;
    logic [2*MAX_N-2:0] p;
    r = prod;
    p = {{(MAX_N-2){1'b0}}, poly};
    for (int i = 2*MAX_N-2; i >= 0; i--) begin
      if ((i >= n) && (i <= 2*n-2) && r[i]) begin
        r = r ^ (p << (i - n));
      end else begin
        r = r;
      end
    end
    return r[MAX_N-1:0];
  endfunction

endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^N) multiplier: carry-less product followed by
// reduction modulo POLY. Output is always a fully reduced N-bit value.
module gf_mul
  import gf_pkg::*;
#(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = 7'b1000011
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  localparam logic [MAX_N:0] POLY_EXT = 17'(POLY);

  logic [2*MAX_N-2:0] prod_s;
  logic [MAX_N-1:0]   red_s;

  // Carry-less (XOR-accumulate) partial products.
  always_comb begin
    prod_s = {(2*MAX_N-1){1'b0}};
    for (int i = 0; i < N; i++) begin
      if (b[i]) begin
        prod_s = prod_s ^ ({{(2*MAX_N-1-N){1'b0}}, a} << i);
      end else begin
        prod_s = prod_s;
      end
    end
  end

  assign red_s = gf_reduce(prod_s, POLY_EXT, N);
  assign y     = N'(red_s);

endmodule

// File: rtl/gf_pow_engine.sv
// Multi-cycle y = x^E engine over GF(2^N): left-to-right square-and-multiply,
// one exponent bit per cycle, LANES elements sharing one exponent and FSM.
module gf_pow_engine
  import gf_pkg::*;
#(
  parameter int         N     = 6,
  parameter logic [N:0] POLY  = 7'b1000011,
  parameter int         LANES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*N-1:0] in_x,
  input  logic [N-1:0]       in_exp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_y,
  output logic               busy
);

  localparam int             CW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  CNT_TOP = CW'(N-1);
  localparam logic [N-1:0]   ONE     = {{(N-1){1'b0}}, 1'b1};

  gf_state_t            state_r, state_s;
  logic                 load_s, step_s;
  logic [CW-1:0]        cnt_r;
  logic [N-1:0]         exp_r;
  logic [LANES*N-1:0]   x_r, acc_r, acc_next_s, out_y_r;
  logic                 out_valid_r;
  logic                 exp_bit_s;

  assign exp_bit_s = exp_r[cnt_r];

  // Per-lane datapath: square the accumulator, then multiply by x or by 1.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [N-1:0] sq_s;
    logic [N-1:0] factor_s;
    logic [N-1:0] nxt_s;

    assign factor_s = exp_bit_s ? x_r[k*N +: N] : ONE;

    gf_mul #(.N(N), .POLY(POLY)) u_sq (
      .a (acc_r[k*N +: N]),
      .b (acc_r[k*N +: N]),
      .y (sq_s)
    );

    gf_mul #(.N(N), .POLY(POLY)) u_mul (
      .a (sq_s),
      .b (factor_s),
      .y (nxt_s)
    );

    assign acc_next_s[k*N +: N] = nxt_s;
  end

  // Next-state and control decode for the shared controller.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == {CW{1'b0}}) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register; out_valid is the registered image of "next state is DONE".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, exponent walk and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r     <= {(LANES*N){1'b0}};
      exp_r   <= {N{1'b0}};
      acc_r   <= {(LANES*N){1'b0}};
      cnt_r   <= {CW{1'b0}};
      out_y_r <= {(LANES*N){1'b0}};
    end else if (load_s) begin
      x_r   <= in_x;
      exp_r <= in_exp;
      acc_r <= {LANES{ONE}};
      cnt_r <= CNT_TOP;
    end else if (step_s) begin
      acc_r <= acc_next_s;
      if (cnt_r == {CW{1'b0}}) begin
        out_y_r <= acc_next_s;
      end else begin
        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r != IDLE);
  assign out_valid = out_valid_r;
  assign out_y     = out_y_r;

endmodule
